// File: rtl/serial_fetch_arbiter_if.sv
// Bus bundle between the two CPU fetch requesters, the serial memory pads and the arbiter.
// The slave modport is the arbiter's view; master is the fetch/pad side.
interface serial_fetch_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_gnt;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              ser_addr_out;
    logic              ser_frame;
    logic              ser_sel;
    logic              ser_data_in;
    logic              busy;
    logic [2:0]        state;

    modport slave (
        input  i_req, i_addr, m_req, m_addr, ser_data_in,
        output i_gnt, i_valid, i_data, m_gnt, m_valid, m_data,
               ser_addr_out, ser_frame, ser_sel, busy, state
    );

    modport master (
        output i_req, i_addr, m_req, m_addr, ser_data_in,
        input  i_gnt, i_valid, i_data, m_gnt, m_valid, m_data,
               ser_addr_out, ser_frame, ser_sel, busy, state
    );
endinterface

// File: rtl/serial_fetch_arbiter.sv
// Round-robin arbiter sharing one bit-serial memory port between instruction and microcode fetch.
//  state | meaning
//  IDLE  | waiting for a request; grant issued combinationally in this state
//  ADDR  | shifting latched address out MSB first, ser_frame high
//  WAIT  | bus turnaround, pad quiet
//  DATA  | shifting returned word in MSB first
//  DONE  | word presented on the granted port with a one-cycle valid
module serial_fetch_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    serial_fetch_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_MAX = (MAX_AD > TURNAROUND) ? MAX_AD : TURNAROUND;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam state_t AFTER_ADDR = (TURNAROUND > 0) ? S_WAIT : S_DATA;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] i_data_q, i_data_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              sel_q, sel_d;
    logic              last_m_q, last_m_d;
    logic              grant_i, grant_m;
    logic              gnt_i, gnt_m;
    logic [DATA_W-1:0] shift_next;

    // i wins when alone or when m had the previous grant.
    assign grant_i    = bus.i_req & (~bus.m_req | last_m_q);
    assign grant_m    = bus.m_req & ~grant_i;
    assign shift_next = (shift_q << 1) | DATA_W'(bus.ser_data_in);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        shift_d  = shift_q;
        i_data_d = i_data_q;
        m_data_d = m_data_q;
        sel_d    = sel_q;
        last_m_d = last_m_q;
        gnt_i    = 1'b0;
        gnt_m    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (grant_i || grant_m) begin
                    gnt_i    = grant_i;
                    gnt_m    = grant_m;
                    addr_d   = grant_i ? bus.i_addr : bus.m_addr;
                    sel_d    = grant_m;
                    last_m_d = grant_m;
                    shift_d  = '0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_d = addr_q << 1;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    state_d = AFTER_ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == TA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                shift_d = shift_next;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (sel_q) m_data_d = shift_next;
                    else       i_data_d = shift_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            shift_q  <= '0;
            i_data_q <= '0;
            m_data_q <= '0;
            sel_q    <= 1'b0;
            last_m_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            shift_q  <= shift_d;
            i_data_q <= i_data_d;
            m_data_q <= m_data_d;
            sel_q    <= sel_d;
            last_m_q <= last_m_d;
        end
    end

    // Grants are combinational from the requests, so hold them low while reset is asserted.
    assign bus.i_gnt        = gnt_i & reset_n;
    assign bus.m_gnt        = gnt_m & reset_n;
    assign bus.i_valid      = (state_q == S_DONE) & ~sel_q;
    assign bus.m_valid      = (state_q == S_DONE) &  sel_q;
    assign bus.i_data       = i_data_q;
    assign bus.m_data       = m_data_q;
    assign bus.ser_frame    = (state_q == S_ADDR);
    assign bus.ser_addr_out = (state_q == S_ADDR) & addr_q[ADDR_W-1];
    assign bus.ser_sel      = (state_q != S_IDLE) & sel_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.state        = state_q;
endmodule

// File: tb/tb_serial_fetch_arbiter.sv
// Bench for serial_fetch_arbiter: vector table, hand-written corner sequences and random traffic
// checked against a transaction-level round-robin/memory model; second instance built with no turnaround.
module tb_serial_fetch_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TA = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic          last_m;
    logic [DW-1:0] mdl_i;
    logic [DW-1:0] mdl_m;

    serial_fetch_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    serial_fetch_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    serial_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TURNAROUND(TA)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
    serial_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TURNAROUND(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0));

    always #5 clock = ~clock;

    typedef struct {
        logic          ri;
        logic          rm;
        logic [AW-1:0] ia;
        logic [AW-1:0] ma;
        logic [DW-1:0] word;
        logic          exp_sel;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic model_reset();
        last_m = 1'b1;
        mdl_i  = '0;
        mdl_m  = '0;
    endtask

    // Entered at posedge+2 of a cycle with the DUT idle; returns at posedge+2 of the next idle cycle.
    task automatic run_txn(input logic ri, input logic rm, input logic [AW-1:0] ia,
                           input logic [AW-1:0] ma, input logic [DW-1:0] word,
                           input logic exp_sel, input logic tog);
        logic [AW-1:0] a;
        bus.i_req = ri; bus.m_req = rm; bus.i_addr = ia; bus.m_addr = ma;
        #1;
        chk("i_gnt", bus.i_gnt, {31'd0, ri & ~exp_sel});
        chk("m_gnt", bus.m_gnt, {31'd0, rm & exp_sel});
        chk("idle_state", bus.state, 0);
        a = exp_sel ? ma : ia;
        last_m = exp_sel;
        step();
        bus.i_req = 1'b0; bus.m_req = 1'b0;
        bus.i_addr = AW'($urandom); bus.m_addr = AW'($urandom);
        for (int k = 0; k < AW; k++) begin
            if (k > 0) step();
            if (tog && k == 2) begin
                if (exp_sel) bus.i_req = 1'b1; else bus.m_req = 1'b1;
            end
            #1;
            chk("addr_frame", bus.ser_frame, 1);
            chk("addr_bit", bus.ser_addr_out, {31'd0, a[AW-1-k]});
            chk("addr_sel", bus.ser_sel, {31'd0, exp_sel});
            chk("busy_gnt", {bus.i_gnt, bus.m_gnt}, 0);
            chk("addr_state", bus.state, 1);
        end
        for (int k = 0; k < TA; k++) begin
            step();
            chk("wait_pad", {bus.ser_frame, bus.ser_addr_out}, 0);
            chk("wait_state", bus.state, 2);
        end
        for (int k = 0; k < DW; k++) begin
            step();
            bus.ser_data_in = word[DW-1-k];
            chk("data_state", bus.state, 3);
            chk("data_valid", {bus.i_valid, bus.m_valid}, 0);
        end
        step();
        bus.ser_data_in = 1'($urandom);
        bus.i_req = 1'b0; bus.m_req = 1'b0;
        if (exp_sel) mdl_m = word; else mdl_i = word;
        chk("done_state", bus.state, 4);
        chk("done_sel", bus.ser_sel, {31'd0, exp_sel});
        chk("i_valid", bus.i_valid, {31'd0, ~exp_sel});
        chk("m_valid", bus.m_valid, {31'd0, exp_sel});
        chk("i_data", bus.i_data, mdl_i);
        chk("m_data", bus.m_data, mdl_m);
        step();
        #1;
        chk("back_idle", {bus.state, bus.busy, bus.ser_sel, bus.i_valid, bus.m_valid}, 0);
        chk("idle_no_gnt", {bus.i_gnt, bus.m_gnt}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {bus.i_gnt, bus.m_gnt, bus.i_valid, bus.m_valid, bus.ser_frame,
                            bus.ser_addr_out, bus.ser_sel, bus.busy}, 0);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_data"}, {bus.i_data, bus.m_data}, 0);
    endtask

    initial begin
        logic ri, rm, sel;
        int   offs [5];
        bus.i_req = 0; bus.m_req = 0; bus.i_addr = 0; bus.m_addr = 0; bus.ser_data_in = 0;
        bus0.i_req = 0; bus0.m_req = 0; bus0.i_addr = 0; bus0.m_addr = 0; bus0.ser_data_in = 0;
        model_reset();

        tbl[0] = '{1, 0, 8'hA5, 8'h00, 8'h3C, 0};
        tbl[1] = '{1, 1, 8'h11, 8'h22, 8'hC3, 1};
        tbl[2] = '{1, 1, 8'h33, 8'h44, 8'hF0, 0};
        tbl[3] = '{1, 1, 8'h55, 8'h66, 8'h0F, 1};
        tbl[4] = '{1, 1, 8'h77, 8'h88, 8'h81, 0};
        tbl[5] = '{0, 1, 8'h00, 8'h99, 8'h7E, 1};
        tbl[6] = '{1, 1, 8'hAA, 8'hBB, 8'h18, 0};
        tbl[7] = '{1, 0, 8'hCC, 8'hDD, 8'hE7, 0};
        tbl[8] = '{1, 1, 8'hEE, 8'hFF, 8'h42, 1};

        #3;
        chk_all_zero("reset");
        step();
        reset_n = 1'b1;
        step();
        chk("release_busy", {bus.busy, bus.state}, 0);

        for (int v = 0; v < 9; v++)
            run_txn(tbl[v].ri, tbl[v].rm, tbl[v].ia, tbl[v].ma, tbl[v].word, tbl[v].exp_sel, 0);

        // Reset asserted in each state: IDLE with a pending request, ADDR, WAIT, DATA, DONE.
        offs = '{0, 3, 9, 12, 18};
        for (int r = 0; r < 5; r++) begin
            bus.i_req = 1'b1; bus.i_addr = 8'h5C;
            for (int c = 0; c < offs[r]; c++) begin
                step();
                bus.i_req = 1'b0;
                bus.ser_data_in = 1'($urandom);
            end
            reset_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            bus.i_req = 1'b0;
            model_reset();
            step();
            reset_n = 1'b1;
            step();
            chk("rst_release", {bus.busy, bus.state}, 0);
        end

        // Abort after four data bits; microcode request then has the port first.
        run_txn(1, 1, 8'h12, 8'h34, 8'h99, 0, 0);
        bus.i_req = 1'b1; bus.i_addr = 8'h3A;
        for (int c = 0; c < AW + TA + 5; c++) begin
            step();
            bus.i_req = 1'b0;
            bus.ser_data_in = 1'b1;
        end
        chk("abort_state", bus.state, 3);
        reset_n = 1'b0;
        #1;
        chk("abort_no_valid", {bus.i_valid, bus.m_valid}, 0);
        chk("abort_i_data", bus.i_data, 0);
        model_reset();
        step();
        reset_n = 1'b1;
        step();
        run_txn(0, 1, 8'h00, 8'hB6, 8'h6D, 1, 0);
        run_txn(1, 1, 8'h21, 8'h43, 8'h5A, 0, 0);

        // Microcode request raised mid-transaction and withdrawn before IDLE.
        run_txn(1, 0, 8'h0F, 8'h00, 8'hA9, 0, 1);
        step();
        chk("withdrawn_idle", {bus.state, bus.busy, bus.m_gnt}, 0);

        for (int t = 0; t < 40; t++) begin
            ri = 1'($urandom);
            rm = 1'($urandom);
            if (!ri && !rm) rm = 1'b1;
            if (ri && rm) sel = ~last_m;
            else          sel = rm;
            run_txn(ri, rm, AW'($urandom), AW'($urandom), DW'($urandom), sel, 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                step();
                chk("gap_idle", {bus.state, bus.busy}, 0);
            end
        end

        // No-turnaround build: data bits on cycles 9..16, valid on cycle 17.
        bus0.i_req = 1'b1; bus0.i_addr = 8'h96;
        #1;
        chk("ta0_gnt", bus0.i_gnt, 1);
        for (int c = 1; c <= 16; c++) begin
            step();
            bus0.i_req = 1'b0;
            if (c == 8) chk("ta0_last_frame", bus0.ser_frame, 1);
            if (c == 9) chk("ta0_state9", bus0.state, 3);
            if (c >= 9) begin
                logic [7:0] w0;
                w0 = 8'hD2;
                bus0.ser_data_in = w0[16-c];
            end
            chk("ta0_no_valid", bus0.i_valid, 0);
        end
        step();
        chk("ta0_valid17", bus0.i_valid, 1);
        chk("ta0_data", bus0.i_data, 8'hD2);
        chk("ta0_m_valid", bus0.m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
